// File: rtl/gaussian_weight_streamer.sv
// Streams the constant Gaussian kernel weights, one beat per valid/ready handshake,
// tagging each beat with its tap index and (row, col) inside the KW x KW window.
module gaussian_weight_streamer #(
  parameter int KW    = 7,
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    weights_in [KW*KW-1:0],
  input  logic             start,
  input  logic             abort,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_weight,
  output logic [5:0]       m_idx,
  output logic [2:0]       m_row,
  output logic [2:0]       m_col,
  output logic             m_last,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt
);

  localparam int         N_TAPS   = KW * KW;
  localparam logic [5:0] LAST_IDX = 6'(N_TAPS - 1);
  localparam logic [2:0] LAST_COL = 3'(KW - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             valid_q, valid_d;
  logic [DW-1:0]    weight_q, weight_d;
  logic [5:0]       idx_q, idx_d;
  logic [2:0]       row_q, row_d;
  logic [2:0]       col_q, col_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       idx_nxt;

  assign idx_nxt = idx_q + 6'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      weight_q <= '0;
      idx_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      weight_q <= weight_d;
      idx_q    <= idx_d;
      row_q    <= row_d;
      col_q    <= col_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    weight_d = weight_q;
    idx_d    = idx_q;
    row_d    = row_q;
    col_d    = col_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE accepts start exactly like IDLE so back-to-back passes need no extra bubble.
        if (start && !abort) begin
          state_d  = S_STREAM;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          idx_d    = '0;
          row_d    = '0;
          col_d    = '0;
          weight_d = weights_in[0];
          last_d   = (N_TAPS == 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STREAM: begin
        if (abort) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          last_d  = 1'b0;
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
        end else if (m_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            idx_d    = idx_nxt;
            weight_d = weights_in[idx_nxt];
            last_d   = (idx_nxt == LAST_IDX);
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = row_q + 3'd1;
            end else begin
              col_d = col_q + 3'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign m_valid  = valid_q;
  assign m_weight = weight_q;
  assign m_idx    = idx_q;
  assign m_row    = row_q;
  assign m_col    = col_q;
  assign m_last   = last_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass_cnt = cnt_q;

endmodule
